drum_mac_accumulator: RTL
=========================

DRUM_MAC_ACCUMULATOR -- requirements
Module: drum_mac_accumulator

Interface
REQ-001 Parameter K, default 8: DRUM approximation width passed to the multiplier.
REQ-002 Parameter N, default 16: signed width of operand InA.
REQ-003 Parameter M, default 16: signed width of operand InB.
REQ-004 Parameter ACC_W, default 32: signed accumulator/result width; ACC_W >= N+M SHALL hold.
REQ-005 Clock  input  1  single clock, rising-edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 Clear  input  1  synchronous abort of the current packet.
REQ-008 InValid  input  1  operand pair valid.
REQ-009 InReady  output  1  block accepts the operand pair this cycle.
REQ-010 InA  input  N  signed operand A (weight).
REQ-011 InB  input  M  signed operand B (input activation).
REQ-012 InLast  input  1  marks the final pair of a packet.
REQ-013 OutValid  output  1  packet result valid.
REQ-014 OutReady  input  1  downstream accepts the result.
REQ-015 OutSum  output  ACC_W  signed saturated packet sum.
REQ-016 OutSat  output  1  sticky: saturation occurred within this packet.

Function
REQ-017 Global advance adv = !(OutValid && !OutReady); InReady SHALL equal adv; no register other than Clear handling changes when adv is 0.
REQ-018 Stage 1: on a rising edge with adv, S1 registers SHALL capture InA, InB, InLast and valid1 = InValid.
REQ-019 Product: S1 operands SHALL feed one combinational DRUM multiplier; its N+M-bit signed result SHALL be captured into stage-2 register P with valid2/last2 on adv.
REQ-020 Accumulate: on adv with valid2, sum = acc + sign-extended P, computed in ACC_W+1 bits, clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clamp SHALL set the packet's sticky saturation flag.
REQ-021 If last2 is 0, acc SHALL take the clamped sum; if last2 is 1, OutSum SHALL take the clamped sum, OutSat the flag (including this term), OutValid SHALL go 1, and acc and flag SHALL clear to 0.
REQ-022 Latency: a last pair accepted at edge E0 SHALL present OutValid after edge E2 when no stall occurs; throughput SHALL be one pair per cycle.
REQ-023 A result handshake (OutValid && OutReady) with no new last term SHALL drop OutValid on the next edge; one coinciding with a new last term SHALL load the new result with OutValid remaining 1.
REQ-024 A single-term packet (InLast with the first pair) SHALL produce that product as OutSum.
REQ-025 Accumulator FSM states: IDLE (acc empty), ACCUM (partial packet), DONE (result held). Transitions: IDLE->ACCUM on valid2 with !last2; IDLE/ACCUM->DONE on valid2 with last2; DONE->IDLE on handshake with no valid2; DONE->ACCUM on handshake with valid2 and !last2; DONE stays on handshake with valid2 and last2.
REQ-026 Clear=1 SHALL on the next edge zero valid1, valid2, acc and the flag, drop OutValid, and go to IDLE; Clear overrides adv and the handshake; InReady SHALL be 0 while Clear=1.
REQ-027 Bubbles (InValid=0) SHALL not disturb acc or the FSM.

Reset
REQ-028 Reset SHALL asynchronously force valid1=valid2=0, acc=0, flag=0, OutSum=0, OutSat=0, OutValid=0, FSM=IDLE; InReady SHALL be 1 once Reset deasserts.
REQ-029 Reset mid-packet SHALL discard all partial state; the first pair after release SHALL start a new packet.

Structure
REQ-030 A shared package/header SHALL hold the FSM state encodings and the ACC_W-derived saturation max/min constants.
REQ-031 The existing DRUMk_n_m_s multiplier SHALL be instantiated as the only sub-module with parameters (K, N, M); all sequential logic SHALL reside in this block.

Verification (K=8, N=M=16, ACC_W=32)
REQ-032 Pairs (3,5),(7,2,last) back-to-back, OutReady=1 -> OutSum=29, OutSat=0, OutValid one cycle, two edges after last accepted.
REQ-033 Three pairs (32767,32767), last on third -> each product 1065369600; OutSum=2147483647, OutSat=1; two-pair packet -> 2130739200, OutSat=0.
REQ-034 Result pending with OutReady=0 for 4 cycles while InValid=1 -> InReady=0, OutSum stable, no pair lost; after release the next packet sums correctly.
REQ-035 Clear asserted after two non-last pairs, then (4,4,last) -> OutSum=16, no OutValid for the aborted packet.
REQ-036 Reset asserted mid-packet between edges -> outputs zero immediately; post-release (2,3,last) -> OutSum=6.
REQ-037 Random signed operands with random stalls -> OutSum/OutSat match a golden DRUM-plus-saturating-accumulate model.

Source files
------------

// File: rtl/drum_mac_accumulator_pkg.sv
// drum_mac_accumulator_pkg: shared FSM encodings and saturation limits for the DRUM MAC accumulator.
package drum_mac_accumulator_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_e;
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction
  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction
endpackage

// File: rtl/drum_mac_accumulator_drum.sv
// DRUMk_n_m_s: signed DRUM approximate multiplier keeping the K leading bits of each magnitude.
module DRUMk_n_m_s #(
  parameter int K = 8,
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic [N-1:0]   a_i,
  input  logic [M-1:0]   b_i,
  output logic [N+M-1:0] r_o
);
  logic [N-1:0] ua;
  logic [M-1:0] ub;
  logic [K-1:0] ta, tb;
  logic [2*K-1:0] pk;
  logic [N+M-1:0] pm;
  int la, lb, sa, sb;
  always_comb begin
    ua = a_i[N-1] ? -a_i : a_i;
    ub = b_i[M-1] ? -b_i : b_i;
    la = 0;
    lb = 0;
    for (int i = 0; i < N; i++) if (ua[i]) la = i;
    for (int i = 0; i < M; i++) if (ub[i]) lb = i;
    sa = (la >= K) ? la - K + 1 : 0;
    sb = (lb >= K) ? lb - K + 1 : 0;
    // truncated segments get their LSB forced to 1 to unbias the error
    ta = K'(ua >> sa) | K'(sa != 0);
    tb = K'(ub >> sb) | K'(sb != 0);
    pk = ta * tb;
    pm = (N+M)'(pk) << (sa + sb);
    r_o = (a_i[N-1] ^ b_i[M-1]) ? -pm : pm;
  end
endmodule

// File: rtl/drum_mac_accumulator.sv
// drum_mac_accumulator: two-stage DRUM multiply then saturating per-packet accumulate with valid/ready.
module drum_mac_accumulator
  import drum_mac_accumulator_pkg::*;
#(
  parameter int K     = 8,
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     in_a_i,
  input  logic [M-1:0]     in_b_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_sum_o,
  output logic             out_sat_o
);
  localparam logic [ACC_W-1:0] MAX_C = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] MIN_C = ACC_W'(sat_min(ACC_W));
  state_e state_q, state_d;
  logic [N-1:0] a1_q;
  logic [M-1:0] b1_q;
  logic v1_q, l1_q, v2_q, l2_q, adv, ovf;
  logic [N+M-1:0] prod, p2_q;
  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, clamp;
  logic [ACC_W:0] sum_w;
  logic flag_q, flag_d, sat_q, sat_d;

  DRUMk_n_m_s #(.K(K), .N(N), .M(M)) u_drum (.a_i(a1_q), .b_i(b1_q), .r_o(prod));

  assign adv         = !(out_valid_o && !out_ready_i);
  assign in_ready_o  = adv && !clear_i;
  assign out_valid_o = state_q == S_DONE;
  assign out_sum_o   = sum_q;
  assign out_sat_o   = sat_q;
  // one guard bit: overflow shows as disagreement of the top two bits
  assign sum_w = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-N-M){p2_q[N+M-1]}}, p2_q};
  assign ovf   = sum_w[ACC_W] != sum_w[ACC_W-1];
  assign clamp = ovf ? (sum_w[ACC_W] ? MIN_C : MAX_C) : sum_w[ACC_W-1:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    flag_d  = flag_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    if (clear_i) begin
      state_d = S_IDLE;
      acc_d   = '0;
      flag_d  = 1'b0;
    end else if (adv) begin
      if (v2_q && l2_q) begin
        state_d = S_DONE;
        sum_d   = clamp;
        sat_d   = flag_q | ovf;
        acc_d   = '0;
        flag_d  = 1'b0;
      end else if (v2_q) begin
        state_d = S_ACCUM;
        acc_d   = clamp;
        flag_d  = flag_q | ovf;
      end else if (state_q == S_DONE) begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      flag_q  <= 1'b0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      l1_q    <= 1'b0;
      v1_q    <= 1'b0;
      p2_q    <= '0;
      l2_q    <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flag_q  <= flag_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
      if (clear_i) begin
        v1_q <= 1'b0;
        v2_q <= 1'b0;
      end else if (adv) begin
        a1_q <= in_a_i;
        b1_q <= in_b_i;
        l1_q <= in_last_i;
        v1_q <= in_valid_i;
        p2_q <= prod;
        l2_q <= l1_q;
        v2_q <= v1_q;
      end
    end
  end
endmodule
